// File: rtl/acq_seq_pkg.sv
// ============================================================================
// Module   : acq_seq_pkg
// Brief    : Shared state encoding and default widths for the acquisition
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package acq_seq_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_CNT_W  = 24;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_ACQ     = 3'd2,
      S_DRAIN   = 3'd3,
      S_READOUT = 3'd4,
      S_DONE    = 3'd5
   } state_e;

endpackage

`default_nettype wire

// File: rtl/quiet_timer.sv
// ============================================================================
// Module   : quiet_timer
// Brief    : Counts consecutive fifo_empty cycles; flags the pipeline drained.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quiet_timer #(
   parameter int DRAIN_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic fifo_empty,
   output logic drained
);

   localparam int              CNT_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DRAIN_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // drained fires combinationally on the final quiet cycle so the caller's
   // registered transition lands exactly DRAIN_CYCLES edges after entry.
   always_comb begin
      cnt_d   = cnt_q;
      drained = 1'b0;
      if (clear || !fifo_empty) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         drained = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

`default_nettype wire

// File: rtl/acq_sequencer.sv
// ============================================================================
// Module   : acq_sequencer
// Brief    : Run controller: clear histogram RAM, acquire, drain, UART dump.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acq_sequencer
   import acq_seq_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  n_samples,
   input  logic              sample_valid,
   input  logic              fifo_empty,
   input  logic              fifo_full,
   input  logic              uart_done,
   output logic              spi_stop,
   output logic              ram_sel,
   output logic              clr_wen,
   output logic [ADDR_W-1:0] clr_addr,
   output logic [DATA_W-1:0] clr_data,
   output logic              uart_start,
   output logic              busy,
   output logic              overflow,
   output logic [2:0]        state
);

   state_e            state_q, state_d;
   logic              start_q;
   logic [CNT_W-1:0]  n_lat_q, n_lat_d;
   logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
   logic              spi_stop_q, spi_stop_d;
   logic              ram_sel_q, ram_sel_d;
   logic              clr_wen_q, clr_wen_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              uart_start_q, uart_start_d;
   logic              busy_q, busy_d;
   logic              overflow_q, overflow_d;

   logic              start_rise;
   logic              drained;
   logic [CNT_W-1:0]  cnt_inc;

   assign start_rise = start & ~start_q;
   assign cnt_inc    = (sample_cnt_q == '1) ? sample_cnt_q : sample_cnt_q + CNT_W'(1);

   quiet_timer #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_quiet_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      (state_q != S_DRAIN),
      .fifo_empty (fifo_empty),
      .drained    (drained)
   );

   always_comb begin
      state_d      = state_q;
      n_lat_d      = n_lat_q;
      sample_cnt_d = sample_cnt_q;
      ram_sel_d    = 1'b0;
      clr_wen_d    = 1'b0;
      clr_addr_d   = clr_addr_q;
      uart_start_d = 1'b0;
      overflow_d   = overflow_q;

      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               state_d      = S_CLEAR;
               n_lat_d      = n_samples;
               sample_cnt_d = '0;
               overflow_d   = 1'b0;
               clr_addr_d   = '0;
               clr_wen_d    = 1'b1;
               ram_sel_d    = 1'b1;
            end
         end
         S_CLEAR: begin
            if (abort) begin
               state_d    = S_IDLE;
               clr_addr_d = '0;
            end else if (clr_addr_q == '1) begin
               clr_addr_d = '0;
               state_d    = (n_lat_q == '0) ? S_DRAIN : S_ACQ;
            end else begin
               clr_addr_d = clr_addr_q + ADDR_W'(1);
               clr_wen_d  = 1'b1;
               ram_sel_d  = 1'b1;
            end
         end
         S_ACQ: begin
            if (abort) begin
               state_d = S_DRAIN;
            end else if (sample_valid) begin
               sample_cnt_d = cnt_inc;
               if (cnt_inc == n_lat_q) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drained) begin
               state_d      = S_READOUT;
               uart_start_d = 1'b1;
            end
         end
         S_READOUT: begin
            if (uart_done) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if ((state_q == S_ACQ || state_q == S_DRAIN) && fifo_full) overflow_d = 1'b1;

      spi_stop_d = (state_d != S_ACQ);
      busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         n_lat_q      <= '0;
         sample_cnt_q <= '0;
         spi_stop_q   <= 1'b1;
         ram_sel_q    <= 1'b0;
         clr_wen_q    <= 1'b0;
         clr_addr_q   <= '0;
         uart_start_q <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start;
         n_lat_q      <= n_lat_d;
         sample_cnt_q <= sample_cnt_d;
         spi_stop_q   <= spi_stop_d;
         ram_sel_q    <= ram_sel_d;
         clr_wen_q    <= clr_wen_d;
         clr_addr_q   <= clr_addr_d;
         uart_start_q <= uart_start_d;
         busy_q       <= busy_d;
         overflow_q   <= overflow_d;
      end
   end

   assign spi_stop   = spi_stop_q;
   assign ram_sel    = ram_sel_q;
   assign clr_wen    = clr_wen_q;
   assign clr_addr   = clr_addr_q;
   assign clr_data   = '0;
   assign uart_start = uart_start_q;
   assign busy       = busy_q;
   assign overflow   = overflow_q;
   assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_acq_sequencer.sv
// ============================================================================
// Module   : tb_acq_sequencer
// Brief    : Directed self-checking bench for acq_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acq_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [23:0] n_samples;
   logic        sample_valid;
   logic        fifo_empty;
   logic        fifo_full;
   logic        uart_done;
   logic        spi_stop;
   logic        ram_sel;
   logic        clr_wen;
   logic [9:0]  clr_addr;
   logic [15:0] clr_data;
   logic        uart_start;
   logic        busy;
   logic        overflow;
   logic [2:0]  state;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   acq_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .n_samples    (n_samples),
      .sample_valid (sample_valid),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .uart_done    (uart_done),
      .spi_stop     (spi_stop),
      .ram_sel      (ram_sel),
      .clr_wen      (clr_wen),
      .clr_addr     (clr_addr),
      .clr_data     (clr_data),
      .uart_start   (uart_start),
      .busy         (busy),
      .overflow     (overflow),
      .state        (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic start_run(input logic [23:0] n);
      n_samples = n;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic run_clear(output int cyc, output int errs);
      cyc  = 0;
      errs = 0;
      while (state == 3'd1 && cyc < 1100) begin
         if (clr_addr !== cyc[9:0] || clr_wen !== 1'b1 || ram_sel !== 1'b1 || clr_data !== 16'd0)
            errs++;
         cyc++;
         step();
      end
   endtask

   task automatic wait_uart(output int cyc);
      cyc = 0;
      while (uart_start !== 1'b1 && cyc < 50) begin
         cyc++;
         step();
      end
   endtask

   task automatic pulse();
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
   endtask

   task automatic finish_readout();
      uart_done = 1'b1;
      step();
      uart_done = 1'b0;
      check("done_state", state, 5);
      check("done_busy", busy, 0);
      step();
      check("idle_after_done", state, 0);
   endtask

   initial begin
      int cyc, errs, k;
      rst = 1'b1; start = 1'b0; abort = 1'b0; n_samples = '0;
      sample_valid = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0; uart_done = 1'b0;
      step(); step();
      check("rst_state", state, 0);
      check("rst_spi_stop", spi_stop, 1);
      check("rst_busy", busy, 0);
      check("rst_clr_wen", clr_wen, 0);
      check("rst_ram_sel", ram_sel, 0);
      check("rst_clr_addr", clr_addr, 0);
      check("rst_uart_start", uart_start, 0);
      check("rst_overflow", overflow, 0);
      check("rst_count", dut.sample_cnt_q, 0);
      rst = 1'b0;
      step();

      // Normal run of 5 samples
      start_run(24'd5);
      check("t1_clear_state", state, 1);
      check("t1_clear_busy", busy, 1);
      run_clear(cyc, errs);
      check("t1_clr_cycles", cyc, 1024);
      check("t1_clr_seq_errs", errs, 0);
      check("t1_acq_state", state, 2);
      check("t1_acq_clr_wen", clr_wen, 0);
      check("t1_acq_ram_sel", ram_sel, 0);
      check("t1_acq_clr_addr", clr_addr, 0);
      check("t1_acq_spi_stop", spi_stop, 0);
      for (int i = 0; i < 4; i++) begin
         pulse();
         step();
      end
      check("t1_spi_stop_after4", spi_stop, 0);
      check("t1_state_after4", state, 2);
      pulse();
      check("t1_spi_stop_after5", spi_stop, 1);
      check("t1_drain_state", state, 3);
      check("t1_count", dut.sample_cnt_q, 5);
      wait_uart(cyc);
      check("t1_drain_cycles", cyc, 8);
      check("t1_readout_state", state, 4);
      step();
      check("t1_uart_start_single", uart_start, 0);
      finish_readout();

      // Drain with intermittent non-empty FIFO
      start_run(24'd1);
      run_clear(cyc, errs);
      fifo_empty = 1'b0;
      pulse();
      check("t2_drain_state", state, 3);
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         fifo_empty = (i % 5 != 4);
         step();
         if (state !== 3'd3) errs++;
      end
      check("t2_no_early_readout", errs, 0);
      fifo_empty = 1'b1;
      wait_uart(cyc);
      check("t2_drain_cycles", cyc, 8);
      finish_readout();

      // Abort after 3 of 10 samples
      start_run(24'd10);
      run_clear(cyc, errs);
      for (int i = 0; i < 3; i++) begin
         pulse();
         step();
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t3_abort_state", state, 3);
      check("t3_abort_spi_stop", spi_stop, 1);
      check("t3_count", dut.sample_cnt_q, 3);
      pulse();
      check("t3_count_drain_sample", dut.sample_cnt_q, 3);
      wait_uart(cyc);
      check("t3_uart_start", uart_start, 1);
      check("t3_overflow", overflow, 0);
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("t3_readout_ignores", state, 4);
      finish_readout();

      // Overflow sticky until next start
      start_run(24'd2);
      run_clear(cyc, errs);
      fifo_full = 1'b1;
      step();
      fifo_full = 1'b0;
      check("t4_overflow_set", overflow, 1);
      pulse();
      step();
      pulse();
      check("t4_drain_state", state, 3);
      wait_uart(cyc);
      check("t4_readout_state", state, 4);
      uart_done = 1'b1;
      step();
      uart_done = 1'b0;
      check("t4_done_state", state, 5);
      check("t4_done_overflow", overflow, 1);
      step();
      check("t4_idle_overflow", overflow, 1);

      // Start edge during clear ignored, abort during clear
      start_run(24'd3);
      check("t5_overflow_cleared", overflow, 0);
      check("t5_clear_state", state, 1);
      k = 0;
      while (clr_addr != 10'd100 && k < 200) begin
         start = (clr_addr == 10'd50);
         step();
         k++;
      end
      start = 1'b0;
      check("t5_start_in_clear_ignored", state, 1);
      check("t5_clr_addr_100", clr_addr, 100);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t5_abort_state", state, 0);
      check("t5_abort_clr_wen", clr_wen, 0);
      check("t5_abort_ram_sel", ram_sel, 0);
      check("t5_abort_busy", busy, 0);
      uart_done = 1'b1;
      step();
      uart_done = 1'b0;
      check("t5_uart_done_idle_ignored", state, 0);

      // Reset mid-ACQ, then zero-sample run
      start_run(24'd5);
      run_clear(cyc, errs);
      check("t6_acq_state", state, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_rst_state", state, 0);
      check("t6_rst_spi_stop", spi_stop, 1);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_clr_wen", clr_wen, 0);
      start_run(24'd0);
      run_clear(cyc, errs);
      check("t6_clr_cycles", cyc, 1024);
      check("t6_clear_to_drain", state, 3);
      wait_uart(cyc);
      check("t6_drain_cycles", cyc, 8);
      check("t6_readout_state", state, 4);
      finish_readout();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire
